// File: rtl/video_out_align_if.sv
// Video output alignment bus: raster timing and pixel FIFO read port towards
// the aligner, aligned pixel stream, syncs and underflow count back out.
interface video_out_align_if #(
    parameter int DATA_W = 8
);
    logic              clk_en;
    logic [11:0]       h_pos;
    logic [11:0]       v_pos;
    logic              pixel_en;
    logic              h_sync;
    logic              v_sync;
    logic              c_sync;
    logic              h_blank;
    logic              v_blank;
    logic              pixel_rd_valid;
    logic [DATA_W-1:0] y_in;
    logic [DATA_W-1:0] u_in;
    logic [DATA_W-1:0] v_in;
    logic              pixel_rd_en;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] v;
    logic              h_sync_out;
    logic              v_sync_out;
    logic              c_sync_out;
    logic              de;
    logic [15:0]       underflow_cnt;

    modport master (
        output clk_en, h_pos, v_pos, pixel_en, h_sync, v_sync, c_sync,
               h_blank, v_blank, pixel_rd_valid, y_in, u_in, v_in,
        input  pixel_rd_en, y, u, v, h_sync_out, v_sync_out, c_sync_out,
               de, underflow_cnt
    );

    modport slave (
        input  clk_en, h_pos, v_pos, pixel_en, h_sync, v_sync, c_sync,
               h_blank, v_blank, pixel_rd_valid, y_in, u_in, v_in,
        output pixel_rd_en, y, u, v, h_sync_out, v_sync_out, c_sync_out,
               de, underflow_cnt
    );
endinterface

// File: rtl/video_out_align.sv
// Video output alignment: pulls pixels from the FIFO in step with the sync
// generator and presents pixel, syncs and data enable two dot enables later.
// A starved FIFO blanks the rest of the frame to black; missed pixels are
// counted (saturating) and reading restarts at the next frame start.
module video_out_align #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] BLACK_Y = 8'd16,
    parameter logic [DATA_W-1:0] BLACK_C = 8'd128
) (
    input  logic             clk,
    input  logic             rst,
    video_out_align_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, UNDERRUN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              pix;
    logic              fs;
    logic              run_px;
    logic              rd_en;
    logic              miss;
    logic              hs_p1, vs_p1, cs_p1, vld_p1, rd_p1;
    logic              rd_pend;
    logic [DATA_W-1:0] y_hold, u_hold, v_hold;
    logic              hs_p2, vs_p2, cs_p2, vld_p2;
    logic [DATA_W-1:0] y_p2, u_p2, v_p2;
    logic [15:0]       underflow_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Dot qualifiers: a visible dot on this enable, and the frame-start dot.
    always_comb begin
        pix = bus.clk_en & bus.pixel_en;
        fs  = pix & (bus.h_pos == 12'd0) & (bus.v_pos == 12'd0);
    end

    // Next state plus read/miss decision; outside RUN only the frame-start dot is a run dot.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        miss    = 1'b0;
        run_px  = (state_q == RUN) ? pix : fs;
        if (run_px) begin
            if (bus.pixel_rd_valid) begin
                rd_en   = 1'b1;
                state_d = RUN;
            end else begin
                miss    = 1'b1;
                state_d = UNDERRUN;
            end
        end else if (pix && (state_q == UNDERRUN)) begin
            miss = 1'b1;
        end
    end

    assign bus.pixel_rd_en = rd_en & rst;

    // State register; state_d already holds when clk_en is low.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Saturating count of visible pixels that got no FIFO data.
    always_ff @(posedge clk) begin
        if (!rst)      underflow_q <= 16'd0;
        else if (miss) underflow_q <= sat_inc(underflow_q);
    end

    // Stage 1: syncs, data enable and read flag of the current dot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            cs_p1  <= 1'b0;
            vld_p1 <= 1'b0;
            rd_p1  <= 1'b0;
        end else if (bus.clk_en) begin
            hs_p1  <= bus.h_sync;
            vs_p1  <= bus.v_sync;
            cs_p1  <= bus.c_sync;
            vld_p1 <= bus.pixel_en;
            rd_p1  <= bus.pixel_rd_en;
        end
    end

    // FIFO data arrives one clk after the strobe; flag that clk.
    always_ff @(posedge clk) begin
        if (!rst) rd_pend <= 1'b0;
        else      rd_pend <= bus.pixel_rd_en;
    end

    // Keep the read data for when clk_en was low on the arrival clk.
    always_ff @(posedge clk) begin
        if (rd_pend) begin
            y_hold <= bus.y_in;
            u_hold <= bus.u_in;
            v_hold <= bus.v_in;
        end
    end

    // Stage 2: shift syncs out and pick FIFO data (live or held) or black.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_p2  <= 1'b0;
            vs_p2  <= 1'b0;
            cs_p2  <= 1'b0;
            vld_p2 <= 1'b0;
            y_p2   <= BLACK_Y;
            u_p2   <= BLACK_C;
            v_p2   <= BLACK_C;
        end else if (bus.clk_en) begin
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            cs_p2  <= cs_p1;
            vld_p2 <= vld_p1;
            if (rd_p1) begin
                y_p2 <= rd_pend ? bus.y_in : y_hold;
                u_p2 <= rd_pend ? bus.u_in : u_hold;
                v_p2 <= rd_pend ? bus.v_in : v_hold;
            end else begin
                y_p2 <= BLACK_Y;
                u_p2 <= BLACK_C;
                v_p2 <= BLACK_C;
            end
        end
    end

    assign bus.h_sync_out    = hs_p2;
    assign bus.v_sync_out    = vs_p2;
    assign bus.c_sync_out    = cs_p2;
    assign bus.de            = vld_p2;
    assign bus.y             = y_p2;
    assign bus.u             = u_p2;
    assign bus.v             = v_p2;
    assign bus.underflow_cnt = underflow_q;
endmodule

// File: tb/tb_video_out_align.sv
// Bench for video_out_align: small raster, random FIFO contents, scoreboard
// of expected output dots filled by a frame-level reference model.
module tb_video_out_align;
    localparam int H_TOT = 16;
    localparam int H_VIS = 12;
    localparam int V_TOT = 6;
    localparam int V_VIS = 4;
    localparam int MEM_N = 8192;

    typedef logic [27:0] out_t;   // {hs, vs, cs, de, y, u, v}
    localparam out_t BUBBLE = {4'b0000, 8'd16, 8'd128, 8'd128};

    logic clk = 1'b0;
    logic rst = 1'b0;

    video_out_align_if #(.DATA_W(8)) bus ();

    video_out_align #(.DATA_W(8), .BLACK_Y(8'd16), .BLACK_C(8'd128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [MEM_N];
    int unsigned rd_ptr  = 0;
    int unsigned exp_ptr = 0;
    out_t        exp_q [$];
    out_t        last_exp = BUBBLE;
    logic [15:0] mdl_cnt  = 16'd0;
    bit          seen_fs  = 1'b0;
    bit          missed   = 1'b0;
    bit          force_vis = 1'b0;
    int          hc = 5;
    int          vc = 2;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One dot: drive inputs, run the reference model, follow the FIFO strobe.
    task automatic dot(input bit en, input bit valid, input bit rst_n);
        bit   pe, fs, rd, hs, vs, rd_now;
        out_t e;
        @(negedge clk);
        hs = (hc >= 13) && (hc <= 14);
        vs = (vc == 5);
        bus.h_blank        = (hc >= H_VIS) && !force_vis;
        bus.v_blank        = (vc >= V_VIS) && !force_vis;
        bus.pixel_en       = ~bus.h_blank & ~bus.v_blank;
        pe                 = bus.pixel_en;
        bus.h_pos          = 12'(hc);
        bus.v_pos          = 12'(vc);
        bus.h_sync         = hs;
        bus.v_sync         = vs;
        bus.c_sync         = hs ^ vs;
        bus.clk_en         = en;
        bus.pixel_rd_valid = valid;
        rst                = rst_n;
        rd                 = 1'b0;
        if (!rst_n) begin
            seen_fs = 1'b0;
            missed  = 1'b0;
            mdl_cnt = 16'd0;
            exp_q.delete();
            exp_q.push_back(BUBBLE);
        end else if (en) begin
            // Read while no visible pixel has been missed since the last frame start.
            fs = pe && (hc == 0) && (vc == 0);
            if (fs) begin
                seen_fs = 1'b1;
                missed  = 1'b0;
            end
            if (pe && seen_fs) begin
                if (!missed && valid) rd = 1'b1;
                else begin
                    missed = 1'b1;
                    if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
                end
            end
            e[27:24] = {hs, vs, hs ^ vs, pe};
            if (rd) begin
                e[23:0] = mem[exp_ptr % MEM_N];
                exp_ptr++;
            end else begin
                e[23:0] = {8'd16, 8'd128, 8'd128};
            end
            exp_q.push_back(e);
        end
        if (en) begin
            hc++;
            if (hc == H_TOT) begin
                hc = 0;
                vc = (vc == V_TOT - 1) ? 0 : vc + 1;
            end
        end
        #1;
        check("rd_en", 32'(bus.pixel_rd_en), 32'(rd));
        rd_now = bus.pixel_rd_en;
        @(posedge clk);
        #1;
        if (rd_now) begin
            {bus.y_in, bus.u_in, bus.v_in} = mem[rd_ptr % MEM_N];
            rd_ptr++;
        end else begin
            {bus.y_in, bus.u_in, bus.v_in} = 24'($urandom);
        end
    endtask

    // Monitor: each enabled edge retires one expected dot; otherwise outputs hold.
    initial begin
        bit   en_s, rst_s;
        out_t cur, e;
        forever begin
            @(posedge clk);
            en_s  = bus.clk_en;
            rst_s = rst;
            #1;
            cur = {bus.h_sync_out, bus.v_sync_out, bus.c_sync_out, bus.de,
                   bus.y, bus.u, bus.v};
            if (!rst_s) begin
                check("reset_out", 32'(cur), 32'(BUBBLE));
                check("reset_cnt", 32'(bus.underflow_cnt), 32'd0);
                last_exp = BUBBLE;
            end else if (en_s) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty: got %0h with nothing expected at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out", 32'(cur), 32'(e));
                    last_exp = e;
                end
                check("underflow_cnt", 32'(bus.underflow_cnt), 32'(mdl_cnt));
            end else begin
                check("hold", 32'(cur), 32'(last_exp));
                check("hold_cnt", 32'(bus.underflow_cnt), 32'(mdl_cnt));
            end
        end
    end

    // Stimulus phases.
    initial begin
        for (int i = 0; i < MEM_N; i++) mem[i] = 24'($urandom);
        bus.clk_en = 1'b0;
        bus.h_pos = '0;
        bus.v_pos = '0;
        bus.pixel_en = 1'b0;
        bus.h_sync = 1'b0;
        bus.v_sync = 1'b0;
        bus.c_sync = 1'b0;
        bus.h_blank = 1'b1;
        bus.v_blank = 1'b1;
        bus.pixel_rd_valid = 1'b0;
        {bus.y_in, bus.u_in, bus.v_in} = 24'($urandom);

        // Reset, then start mid-frame with a full FIFO: no reads before frame start.
        repeat (3) dot(1'b1, 1'b1, 1'b0);
        repeat (2 * H_TOT * V_TOT + 20) dot(1'b1, 1'b1, 1'b1);

        // Dot enable every third clk: read data reaches the output via the hold registers.
        for (int i = 0; i < 3 * H_TOT * V_TOT; i++) dot(i % 3 == 0, 1'b1, 1'b1);

        // Random enable and occasional empty FIFO.
        for (int i = 0; i < 4 * H_TOT * V_TOT; i++)
            dot(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0, 1'b1);

        // Three empty dots mid-line, then a clean frame.
        while (!(hc == 0 && vc == 0)) dot(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < H_TOT * V_TOT; i++)
            dot(1'b1, !(vc == 1 && hc >= 4 && hc <= 6), 1'b1);
        repeat (H_TOT * V_TOT) dot(1'b1, 1'b1, 1'b1);

        // One-clk reset mid-line, reading resumes at the next frame start.
        repeat (30) dot(1'b1, 1'b1, 1'b1);
        dot(1'b0, 1'b1, 1'b0);
        repeat (150) dot(1'b1, 1'b1, 1'b1);

        // Drive the miss counter into saturation.
        force_vis = 1'b1;
        repeat (70000) dot(1'b1, 1'b0, 1'b1);
        repeat (6) dot(1'b0, 1'b0, 1'b1);
        force_vis = 1'b0;
        repeat (4) dot(1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_out_align.md
VIDEO_OUT_ALIGN -- requirements
Module: video_out_align

Interface
REQ-001 Parameter BLACK_Y, default 8'd16: luma driven when no pixel is available.
REQ-002 Parameter BLACK_C, default 8'd128: chroma (u, v) driven when no pixel is available.
REQ-003 clk  in  1  single clock for the block; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 clk_en  in  1  dot-rate enable; the pipeline SHALL advance only when clk_en=1.
REQ-006 h_pos, v_pos  in  12 each  raster position from the sync generator.
REQ-007 pixel_en  in  1  a visible pixel is due this dot.
REQ-008 h_sync, v_sync, c_sync, h_blank, v_blank  in  1 each  timing from the sync generator.
REQ-009 pixel_rd_valid  in  1  pixel FIFO is non-empty.
REQ-010 y_in, u_in, v_in  in  8 each  FIFO read data, valid on the clk following pixel_rd_en.
REQ-011 pixel_rd_en  out  1  pixel FIFO read strobe, combinational.
REQ-012 y, u, v  out  8 each  output pixel.
REQ-013 h_sync_out, v_sync_out, c_sync_out, de  out  1 each  aligned syncs and data enable.
REQ-014 underflow_cnt  out  16  count of pixels missed due to FIFO empty.

Function
REQ-015 The block SHALL implement the FSM states IDLE, RUN and UNDERRUN.
REQ-016 Frame start (fs) SHALL be defined as clk_en & pixel_en & h_pos==0 & v_pos==0.
REQ-017 IDLE SHALL transition to RUN on fs; IDLE SHALL NOT issue reads.
REQ-018 RUN: pixel_rd_en SHALL equal clk_en & pixel_en & pixel_rd_valid.
REQ-019 RUN: on clk_en & pixel_en & ~pixel_rd_valid, the FSM SHALL go to UNDERRUN and underflow_cnt SHALL increment.
REQ-020 UNDERRUN: pixel_rd_en SHALL be 0; every clk_en & pixel_en SHALL increment underflow_cnt.
REQ-021 UNDERRUN: on fs, the FSM SHALL go to RUN, and that fs pixel SHALL be treated as a RUN pixel (read if valid, else count and stay in UNDERRUN).
REQ-022 underflow_cnt SHALL saturate at 16'hFFFF.
REQ-023 Stage 1 (on clk_en) SHALL register the syncs, de1 = pixel_en, and rd1 = pixel_rd_en.
REQ-024 On the clk edge after any pixel_rd_en, hold registers SHALL capture y_in, u_in and v_in, independent of clk_en.
REQ-025 A flag rd_pend SHALL be set on the edge where pixel_rd_en=1 and cleared on the next edge.
REQ-026 Stage 2 (on clk_en): the syncs SHALL shift out to *_out, and de SHALL be set to de1.
  - Pixel source when rd1=1: y_in/u_in/v_in if rd_pend=1, else the hold registers.
  - Pixel source when rd1=0: BLACK_Y/BLACK_C/BLACK_C.
REQ-027 All outputs SHALL reproduce the inputs of exactly 2 clk_en cycles earlier; the latency SHALL be independent of clk_en duty.
REQ-028 When clk_en=0, all outputs and the FSM SHALL hold, and pixel_rd_en SHALL be 0.
REQ-029 Exactly one read SHALL occur per RUN pixel; no read SHALL occur when de1 would be 0.

Reset
REQ-030 When rst=0 at a clk edge, the following SHALL be cleared: FSM=IDLE, pipeline syncs=0, de=0, rd1=0, rd_pend=0, underflow_cnt=0.
REQ-031 During reset, y SHALL be BLACK_Y and u, v SHALL be BLACK_C.
REQ-032 During reset, pixel_rd_en SHALL be 0.
REQ-033 Reset mid-frame SHALL return the FSM to IDLE; reads SHALL resume only at the next fs.

Verification
REQ-034 Steady state: clk_en=1, FIFO always valid with data Y=h_pos[7:0] -> y at cycle t+2 equals h_pos[7:0] at t, de tracks pixel_en delayed by 2, underflow_cnt=0.
REQ-035 clk_en=1 every third clk -> latency is 2 enabled cycles, and data is captured via the hold registers (rd_pend=0 path).
REQ-036 FIFO empty for 3 pixels mid-line in frame 1 -> underflow_cnt counts 3 plus the rest-of-frame visible pixels, y=16 and u=v=128 from the first miss, no reads until fs; frame 2 with full FIFO -> normal output, underflow_cnt unchanged.
REQ-037 Pixels valid before the first fs -> no pixel_rd_en in IDLE; the first read occurs on the fs cycle.
REQ-038 rst=0 for one clk mid-line -> next edge shows de=0, syncs=0, underflow_cnt=0, pixel_rd_en=0 until fs.
REQ-039 underflow_cnt preset near saturation by 70000 forced misses -> counter holds at 16'hFFFF.
